// File: rtl/feature_mem_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : feature_mem_pkg
//  Purpose  : Shared types and default sizes for the feature-memory server.
//             Holds the controller state enum, word/address widths and the
//             default dump window.
//  Revision : 1.0  initial release
// ============================================================================
package feature_mem_pkg;

   localparam int unsigned FM_ADDR_W     = 12;
   localparam int unsigned FM_DATA_W     = 32;
   localparam int unsigned FM_FINISH_CNT = 3;
   localparam int unsigned FM_DUMP_BASE  = 0;
   localparam int unsigned FM_DUMP_LEN   = 864;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_RUN  = 3'd2,
      ST_DUMP = 3'd3,
      ST_FIN  = 3'd4
   } fm_state_e;

endpackage
`default_nettype wire

// File: rtl/feature_mem_ram.sv
`default_nettype none
// ============================================================================
//  Module   : feature_mem_ram
//  Purpose  : Single-port DEPTH x DATA_W synchronous RAM. The read is
//             registered and returns the word stored before any write
//             performed in the same cycle (read-before-write).
//  Ports    : clk      - clock
//             i_we     - write enable
//             i_addr   - read/write address
//             i_wdata  - write data
//             o_rdata  - registered read data (1-cycle latency)
//  Revision : 1.0  initial release
// ============================================================================
module feature_mem_ram
   import feature_mem_pkg::*;
#(
   parameter int ADDR_W = FM_ADDR_W,
   parameter int DATA_W = FM_DATA_W,
   parameter int DEPTH  = 2 ** FM_ADDR_W
) (
   input  logic              clk,
   input  logic              i_we,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [DATA_W-1:0] i_wdata,
   output logic [DATA_W-1:0] o_rdata
);

   logic [DATA_W-1:0] r_mem [DEPTH];
   logic [DATA_W-1:0] r_rdata;

   // No reset on the array or read register so the store maps onto block RAM.
   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_addr] <= i_wdata;
      end
      r_rdata <= r_mem[i_addr];
   end

   assign o_rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/feature_mem_server.sv
`default_nettype none
// ============================================================================
//  Module   : feature_mem_server
//  Purpose  : Memory-side responder for the PE feature port. Host preloads
//             the store, the block raises start and serves core reads and
//             writes, then streams the result window over a valid/ready port.
//  Ports    : clk, reset (sync, active-low)
//             host_wr_*     - preload write port (valid/ready)
//             load_done     - preload complete pulse
//             start         - run enable to the core
//             feature_*     - core read/write port, 1-cycle read latency
//             instruction_finish, done - core progress/completion
//             dump_*        - result stream (valid/ready)
//             all_done      - dump finished (sticky)
//             proto_err     - sticky protocol error
//  Revision : 1.0  initial release
// ============================================================================
module feature_mem_server
   import feature_mem_pkg::*;
#(
   parameter int ADDR_W     = FM_ADDR_W,
   parameter int DATA_W     = FM_DATA_W,
   parameter int DEPTH      = 2 ** FM_ADDR_W,
   parameter int FINISH_CNT = FM_FINISH_CNT,
   parameter int DUMP_BASE  = FM_DUMP_BASE,
   parameter int DUMP_LEN   = FM_DUMP_LEN
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              host_wr_valid,
   output logic              host_wr_ready,
   input  logic [ADDR_W-1:0] host_wr_addr,
   input  logic [DATA_W-1:0] host_wr_data,
   input  logic              load_done,
   output logic              start,
   input  logic [ADDR_W-1:0] feature_addr,
   input  logic [DATA_W-1:0] feature_data,
   input  logic              feature_mem_en,
   output logic [DATA_W-1:0] feature_idata,
   input  logic              instruction_finish,
   input  logic              done,
   output logic              dump_valid,
   input  logic              dump_ready,
   output logic [ADDR_W-1:0] dump_addr,
   output logic [DATA_W-1:0] dump_data,
   output logic              all_done,
   output logic              proto_err
);

   localparam int                CNT_W       = $clog2(FINISH_CNT + 1);
   localparam logic [CNT_W-1:0]  C_FIN_LAST  = CNT_W'(FINISH_CNT - 1);
   localparam logic [ADDR_W-1:0] C_DUMP_BASE = ADDR_W'(DUMP_BASE);
   localparam logic [ADDR_W-1:0] C_DUMP_LAST = ADDR_W'(DUMP_BASE + DUMP_LEN - 1);

   fm_state_e         r_state;
   fm_state_e         w_next_state;
   logic [CNT_W-1:0]  r_fin_cnt;
   logic              r_fin_prev;
   logic              r_prev_run;
   logic [ADDR_W-1:0] r_dump_addr;
   logic              r_dump_valid;
   logic              r_proto_err;

   logic              w_fin_rise;
   logic              w_dump_hs;
   logic              w_dump_last;
   logic              w_ram_we;
   logic [ADDR_W-1:0] w_ram_addr;
   logic [DATA_W-1:0] w_ram_wdata;
   logic [DATA_W-1:0] w_ram_rdata;

   assign w_fin_rise  = instruction_finish & ~r_fin_prev;
   assign w_dump_hs   = r_dump_valid & dump_ready;
   assign w_dump_last = (r_dump_addr == C_DUMP_LAST);

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // ------------------------------------------- next state, outputs, RAM mux
   always_comb begin
      w_next_state  = r_state;
      host_wr_ready = 1'b0;
      start         = 1'b0;
      all_done      = 1'b0;
      w_ram_we      = 1'b0;
      w_ram_addr    = '0;
      w_ram_wdata   = host_wr_data;
      case (r_state)
         ST_IDLE, ST_LOAD: begin
            host_wr_ready = 1'b1;
            w_ram_we      = host_wr_valid;
            w_ram_addr    = host_wr_addr;
            if (load_done) begin
               w_next_state = ST_RUN;
            end else if (host_wr_valid) begin
               w_next_state = ST_LOAD;
            end
         end
         ST_RUN: begin
            start       = 1'b1;
            w_ram_we    = feature_mem_en;
            w_ram_addr  = feature_addr;
            w_ram_wdata = feature_data;
            if (done || (w_fin_rise && (r_fin_cnt == C_FIN_LAST))) begin
               w_next_state = ST_DUMP;
            end
         end
         ST_DUMP: begin
            start = 1'b1;
            // Fetch ahead on a handshake so the next word is ready with no
            // bubble; otherwise re-read the current word to hold it stable.
            w_ram_addr = (w_dump_hs && !w_dump_last) ? (r_dump_addr + 1'b1)
                                                     : r_dump_addr;
            if (w_dump_hs && w_dump_last) begin
               w_next_state = ST_FIN;
            end
         end
         ST_FIN: begin
            all_done = 1'b1;
         end
         default: begin
            w_next_state = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------- datapath
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_fin_cnt    <= '0;
         r_fin_prev   <= 1'b0;
         r_prev_run   <= 1'b0;
         r_dump_addr  <= C_DUMP_BASE;
         r_dump_valid <= 1'b0;
         r_proto_err  <= 1'b0;
      end else begin
         r_fin_prev <= instruction_finish;
         // Marks that the word now in the RAM read register came from a core read.
         r_prev_run <= (r_state == ST_RUN);
         if ((r_state == ST_RUN) && w_fin_rise) begin
            r_fin_cnt <= r_fin_cnt + 1'b1;
         end
         // First valid follows DUMP entry by one cycle (prefetch read).
         r_dump_valid <= (r_state == ST_DUMP) && !(w_dump_hs && w_dump_last);
         if ((r_state == ST_DUMP) && w_dump_hs && !w_dump_last) begin
            r_dump_addr <= r_dump_addr + 1'b1;
         end
         if ((host_wr_valid && !host_wr_ready) ||
             ((r_state == ST_DUMP) && feature_mem_en)) begin
            r_proto_err <= 1'b1;
         end
      end
   end

   assign feature_idata = ((r_state == ST_RUN) && r_prev_run) ? w_ram_rdata : '0;
   assign dump_valid    = r_dump_valid;
   assign dump_addr     = r_dump_addr;
   assign dump_data     = r_dump_valid ? w_ram_rdata : '0;
   assign proto_err     = r_proto_err;

   feature_mem_ram #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk     (clk),
      .i_we    (w_ram_we),
      .i_addr  (w_ram_addr),
      .i_wdata (w_ram_wdata),
      .o_rdata (w_ram_rdata)
   );

endmodule
`default_nettype wire

// File: tb/tb_feature_mem_server.sv
`default_nettype none
// ============================================================================
//  Module   : tb_feature_mem_server
//  Purpose  : Self-checking bench for feature_mem_server. A phase-level
//             reference model tracks memory contents and expected outputs;
//             a compare process checks every cycle, and literal checks pin
//             the key scenarios.
//  Revision : 1.0  initial release
// ============================================================================
module tb_feature_mem_server;

   localparam int AW    = 12;
   localparam int DW    = 32;
   localparam int DEPTH = 4096;
   localparam int FCNT  = 3;
   localparam int DBASE = 0;
   localparam int DLEN  = 864;

   logic          clk = 1'b0;
   logic          reset;
   logic          host_wr_valid;
   logic          host_wr_ready;
   logic [AW-1:0] host_wr_addr;
   logic [DW-1:0] host_wr_data;
   logic          load_done;
   logic          start;
   logic [AW-1:0] feature_addr;
   logic [DW-1:0] feature_data;
   logic          feature_mem_en;
   logic [DW-1:0] feature_idata;
   logic          instruction_finish;
   logic          done;
   logic          dump_valid;
   logic          dump_ready;
   logic [AW-1:0] dump_addr;
   logic [DW-1:0] dump_data;
   logic          all_done;
   logic          proto_err;

   always #5 clk = ~clk;

   feature_mem_server #(
      .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH),
      .FINISH_CNT(FCNT), .DUMP_BASE(DBASE), .DUMP_LEN(DLEN)
   ) dut (
      .clk(clk), .reset(reset),
      .host_wr_valid(host_wr_valid), .host_wr_ready(host_wr_ready),
      .host_wr_addr(host_wr_addr), .host_wr_data(host_wr_data),
      .load_done(load_done), .start(start),
      .feature_addr(feature_addr), .feature_data(feature_data),
      .feature_mem_en(feature_mem_en), .feature_idata(feature_idata),
      .instruction_finish(instruction_finish), .done(done),
      .dump_valid(dump_valid), .dump_ready(dump_ready),
      .dump_addr(dump_addr), .dump_data(dump_data),
      .all_done(all_done), .proto_err(proto_err)
   );

   int nerr = 0;
   int nchk = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------- reference model
   typedef enum int {P_IDLE, P_LOAD, P_RUN, P_DUMP, P_FIN} phase_t;

   logic [31:0] m_mem   [DEPTH];
   bit          m_known [DEPTH];
   phase_t      m_ph = P_IDLE;
   int          m_cnt = 0;
   bit          m_fprev = 1'b0;
   int          m_idx = 0;
   bit          m_dval = 1'b0;
   bit          m_perr = 1'b0;
   logic [31:0] m_idata = '0;
   bit          m_idata_known = 1'b1;
   bit          m_live = 1'b0;

   always @(posedge clk) begin : model
      logic [31:0] rd;
      bit          rdk;
      if (!reset) begin
         m_ph = P_IDLE; m_cnt = 0; m_fprev = 1'b0; m_idx = 0; m_dval = 1'b0;
         m_perr = 1'b0; m_idata = '0; m_idata_known = 1'b1; m_live = 1'b1;
      end else begin
         m_idata = '0;
         m_idata_known = 1'b1;
         if (host_wr_valid && !(m_ph == P_IDLE || m_ph == P_LOAD)) m_perr = 1'b1;
         case (m_ph)
            P_IDLE, P_LOAD: begin
               if (host_wr_valid) begin
                  m_mem[host_wr_addr] = host_wr_data;
                  m_known[host_wr_addr] = 1'b1;
                  if (m_ph == P_IDLE) m_ph = P_LOAD;
               end
               if (load_done) m_ph = P_RUN;
            end
            P_RUN: begin
               rd  = m_mem[feature_addr];
               rdk = m_known[feature_addr];
               if (feature_mem_en) begin
                  m_mem[feature_addr] = feature_data;
                  m_known[feature_addr] = 1'b1;
               end
               if (instruction_finish && !m_fprev) m_cnt++;
               if (m_cnt == FCNT || done) begin
                  m_ph = P_DUMP; m_idx = 0; m_dval = 1'b0;
               end else begin
                  m_idata = rd; m_idata_known = rdk;
               end
            end
            P_DUMP: begin
               if (feature_mem_en) m_perr = 1'b1;
               if (!m_dval) m_dval = 1'b1;
               else if (dump_ready) begin
                  if (m_idx == DLEN - 1) begin
                     m_dval = 1'b0; m_ph = P_FIN;
                  end else begin
                     m_idx++;
                  end
               end
            end
            default: ;
         endcase
         m_fprev = instruction_finish;
      end
   end

   // ------------------------------------------------------- compare process
   always @(negedge clk) begin
      if (m_live) begin
         chk("start", start, (m_ph == P_RUN || m_ph == P_DUMP));
         chk("host_wr_ready", host_wr_ready, (m_ph == P_IDLE || m_ph == P_LOAD));
         if (m_idata_known) chk("feature_idata", feature_idata, m_idata);
         chk("dump_valid", dump_valid, m_dval);
         chk("dump_addr", dump_addr, 32'(DBASE + m_idx));
         if (!m_dval) chk("dump_data_idle", dump_data, 32'h0);
         else if (m_known[DBASE + m_idx]) chk("dump_data", dump_data, m_mem[DBASE + m_idx]);
         chk("all_done", all_done, (m_ph == P_FIN));
         chk("proto_err", proto_err, m_perr);
      end
   end

   // ------------------------------------------------------------- stimulus
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic hw(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic ld);
      host_wr_valid = 1'b1; host_wr_addr = a; host_wr_data = d; load_done = ld;
      cyc();
      host_wr_valid = 1'b0; load_done = 1'b0;
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
      $fatal(1);
   end

   initial begin : stim
      int hs;
      bit v, r;
      reset = 1'b0; host_wr_valid = 1'b0; host_wr_addr = '0; host_wr_data = '0;
      load_done = 1'b0; feature_addr = '0; feature_data = '0; feature_mem_en = 1'b0;
      instruction_finish = 1'b0; done = 1'b0; dump_ready = 1'b0;
      repeat (3) cyc();
      chk("reset start", start, 0);
      chk("reset dump_valid", dump_valid, 0);
      chk("reset dump_addr", dump_addr, DBASE);
      reset = 1'b1;

      // Preload: known words plus random fill, last write merged with load_done.
      hw(12'd5, 32'hDEADBEEF, 1'b0);
      hw(12'd7, 32'h1, 1'b0);
      for (int i = 0; i < 40; i++) begin
         if ($urandom_range(0, 3) == 0) cyc();
         hw(AW'($urandom_range(8, DEPTH - 1)), $urandom, 1'b0);
      end
      hw(12'd2000, $urandom, 1'b1);
      chk("start after load_done", start, 1);

      // Read of preloaded word.
      feature_addr = 12'd5; cyc();
      chk("read addr5", feature_idata, 32'hDEADBEEF);

      // Same-cycle read/write returns the old word.
      feature_addr = 12'd7; feature_data = 32'h2; feature_mem_en = 1'b1; cyc();
      feature_mem_en = 1'b0;
      chk("collision old data", feature_idata, 32'h1);
      cyc();
      chk("collision new data", feature_idata, 32'h2);

      // Core fills the dump window (addr 5 kept as preloaded), then random traffic.
      for (int i = 0; i < DLEN; i++) begin
         feature_addr = AW'(i); feature_data = $urandom; feature_mem_en = (i != 5);
         cyc();
      end
      for (int i = 0; i < 300; i++) begin
         feature_addr = AW'($urandom_range(0, 1023));
         feature_data = $urandom;
         feature_mem_en = ($urandom_range(0, 1) == 1) && (feature_addr != 12'd5);
         cyc();
      end
      feature_mem_en = 1'b0;

      // Three finish pulses; DUMP entered on the third rising edge.
      for (int k = 0; k < FCNT; k++) begin
         instruction_finish = 1'b1; cyc();
         instruction_finish = 1'b0;
         if (k < FCNT - 1) cyc();
      end
      chk("dump entry start", start, 1);
      chk("dump entry valid", dump_valid, 0);
      cyc();
      chk("first dump_valid", dump_valid, 1);
      chk("first dump_addr", dump_addr, 0);

      // Drain with 1,0,0,1 backpressure first, then random readiness.
      hs = 0;
      for (int c = 0; c < 5000 && !all_done; c++) begin
         if (c < 200) r = (c % 4 == 0) || (c % 4 == 3);
         else         r = ($urandom_range(0, 3) != 0);
         v = dump_valid;
         dump_ready = r;
         if (v && r) hs++;
         cyc();
      end
      dump_ready = 1'b0;
      chk("handshake count", hs, DLEN);
      chk("all_done after dump", all_done, 1);
      chk("start in FIN", start, 0);

      // Host write attempt while not ready.
      chk("proto_err before host poke", proto_err, 0);
      hw(12'd9, 32'h0, 1'b0);
      chk("proto_err host poke", proto_err, 1);

      // Second run: early done, illegal write in DUMP, then reset mid-dump.
      reset = 1'b0; cyc(); reset = 1'b1;
      for (int i = 0; i < 5; i++) hw(AW'(900 + i), $urandom, 1'b0);
      load_done = 1'b1; cyc(); load_done = 1'b0;
      repeat (3) begin
         feature_addr = AW'($urandom_range(0, 1023)); cyc();
      end
      instruction_finish = 1'b1; cyc(); instruction_finish = 1'b0; cyc();
      done = 1'b1; cyc(); done = 1'b0;
      chk("done dump start", start, 1);
      chk("done dump valid", dump_valid, 0);
      feature_addr = 12'd3; feature_data = 32'hBAD0BAD0; feature_mem_en = 1'b1; cyc();
      feature_mem_en = 1'b0;
      chk("proto_err dump write", proto_err, 1);
      dump_ready = 1'b1;
      repeat (20) cyc();
      reset = 1'b0; cyc(); reset = 1'b1; dump_ready = 1'b0;
      chk("mid-dump reset valid", dump_valid, 0);
      chk("mid-dump reset start", start, 0);
      chk("mid-dump reset ready", host_wr_ready, 1);
      load_done = 1'b1; cyc(); load_done = 1'b0;
      feature_addr = 12'd5; cyc();
      chk("addr5 after reset", feature_idata, 32'hDEADBEEF);
      cyc();

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/feature_mem_server.md
Name: feature_mem_server

Overview:
- Synthesizable responder for the processing element's feature-memory port: the memory side of feature_addr / feature_idata / feature_data / feature_mem_en.
- Holds the 4096x32 feature/instruction store. A host preloads it, then the block issues start and serves core reads and writes.
- After the core signals completion, it streams the result region out over a valid/ready dump port.
- Replaces the behavioural feature memory for FPGA bring-up.

Parameters:
- ADDR_W, 12, feature address width
- DATA_W, 32, word width
- DEPTH, 4096, words of storage (2**ADDR_W)
- FINISH_CNT, 3, instruction_finish rising edges that end the run
- DUMP_BASE, 0, first dumped address
- DUMP_LEN, 864, words dumped (1..DEPTH-DUMP_BASE)

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  synchronous, active-low reset
- host_wr_valid  in  1  host preload write request
- host_wr_ready  out  1  preload write accepted
- host_wr_addr  in  ADDR_W  preload address
- host_wr_data  in  DATA_W  preload data
- load_done  in  1  one-cycle pulse: preload complete
- start  out  1  run enable to the core
- feature_addr  in  ADDR_W  core read/write address
- feature_data  in  DATA_W  core write data
- feature_mem_en  in  1  core write enable
- feature_idata  out  DATA_W  read data to the core
- instruction_finish  in  1  core instruction-complete level
- done  in  1  core overall done
- dump_valid  out  1  dump word valid
- dump_ready  in  1  dump sink ready
- dump_addr  out  ADDR_W  address of the current dump word
- dump_data  out  DATA_W  dump word
- all_done  out  1  dump finished (sticky)
- proto_err  out  1  sticky error flag

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - start, dump_valid, all_done and proto_err go to 0; feature_idata and dump_data go to 0; dump_addr goes to DUMP_BASE; the finish counter clears.
  - Memory contents are not cleared.
  - Reset mid-run or mid-dump aborts immediately.
- States: IDLE, LOAD, RUN, DUMP, FIN.
- IDLE/LOAD:
  - host_wr_ready=1. A write occurs when valid&&ready.
  - The first accepted write moves IDLE to LOAD.
  - A load_done pulse in IDLE or LOAD moves to RUN; an empty preload is legal.
  - A write and load_done in the same cycle: the write is performed, then the state moves to RUN.
- RUN:
  - start=1, host_wr_ready=0.
  - Read: feature_idata <= mem[feature_addr] every cycle, giving 1-cycle latency.
  - Write: mem[feature_addr] <= feature_data when feature_mem_en=1.
  - A read and write to the same address in the same cycle returns the OLD data (read-before-write).
  - The finish counter increments on each 0->1 edge of instruction_finish.
  - The state moves to DUMP on the cycle the counter reaches FINISH_CNT, or on done=1, whichever comes first.
- DUMP:
  - start stays 1; feature_idata holds 0.
  - feature_mem_en=1 is ignored and sets proto_err.
  - Words are read from DUMP_BASE up to DUMP_BASE+DUMP_LEN-1. The first dump_valid rises 1 cycle after DUMP entry (prefetch).
  - dump_data and dump_addr stay stable while dump_valid && !dump_ready.
  - Each handshake advances to the next word, with no bubble when dump_ready is held high (1 word/cycle).
  - After the last handshake, dump_valid drops and the state moves to FIN.
- FIN: all_done=1, start=0. The block stays in FIN until reset.
- Outside RUN: feature_idata=0. A host write attempt (host_wr_valid=1 while not ready) sets proto_err.
- Address arithmetic is unsigned ADDR_W. The dump address never wraps, because the legal DUMP_LEN range guarantees it.

Decomposition:
- Shared package feature_mem_pkg holds:
  - the state enum;
  - the ADDR_W/DATA_W defaults;
  - the dump defaults (864, 0).
- One sub-module, feature_mem_ram: single-port DEPTH x DATA_W synchronous RAM with read-before-write and a registered read. The host, core and dump ports are muxed onto it by state.

Test Plan:
- Preload: addr 5 <= 0xDEADBEEF, pulse load_done -> start=1 next cycle; feature_addr=5 -> feature_idata=0xDEADBEEF one cycle later.
- Same-cycle collision: addr 7 holds 0x1, core writes 0x2 to 7 with a read of 7 -> idata=0x1; next-cycle read -> 0x2.
- Finish counting: drive three instruction_finish pulses -> DUMP is entered on the third rising edge; start stays 1; dump_valid rises one cycle later with dump_addr=0.
- Dump backpressure: toggle dump_ready 1,0,0,1 -> data is stable during stalls; 864 handshakes, addresses 0..863 carry the core-written values; then all_done=1, start=0.
- Core done=1 after one finish pulse -> immediate DUMP; a feature_mem_en pulse in DUMP -> proto_err=1 and memory unchanged.
- reset=0 mid-DUMP -> next cycle IDLE, dump_valid=0, start=0; preloaded data at addr 5 is still readable after a fresh load_done.
